// File: rtl/regstat_ckpt.sv
// Register status table (busy + producer ROB tag) with intra-group operand bypass.
// Define REGSTAT_CKPT_EN to build the branch checkpoint ring; without it ckpt_restore acts as flush.
module regstat_ckpt #(
    parameter int unsigned NREG     = 32,
    parameter int unsigned ROB_W    = 4,
    parameter int unsigned ISSUE_W  = 2,
    parameter int unsigned COMMIT_W = 2,
    parameter int unsigned NCKPT    = 4,
    localparam int unsigned RA_W    = $clog2(NREG),
    localparam int unsigned CK_W    = (NCKPT > 1) ? $clog2(NCKPT) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ISSUE_W-1:0]          iss_valid,
    input  logic [ISSUE_W-1:0]          iss_writes,
    input  logic [ISSUE_W*RA_W-1:0]     iss_rd,
    input  logic [ISSUE_W*RA_W-1:0]     iss_rs1,
    input  logic [ISSUE_W*RA_W-1:0]     iss_rs2,
    input  logic [ISSUE_W*ROB_W-1:0]    iss_rob,
    output logic [ISSUE_W*ROB_W-1:0]    q_j,
    output logic [ISSUE_W*ROB_W-1:0]    q_k,
    output logic [ISSUE_W-1:0]          q_j_busy,
    output logic [ISSUE_W-1:0]          q_k_busy,
    input  logic [COMMIT_W-1:0]         cmt_valid,
    input  logic [COMMIT_W-1:0]         cmt_regwrite,
    input  logic [COMMIT_W*RA_W-1:0]    cmt_rd,
    input  logic [COMMIT_W*ROB_W-1:0]   cmt_rob,
    input  logic                        flush,
    input  logic                        ckpt_take,
    input  logic                        ckpt_restore,
    input  logic                        ckpt_free,
    input  logic [CK_W-1:0]             ckpt_restore_id,
    output logic [CK_W-1:0]             ckpt_id,
    output logic                        ckpt_full
);

    logic [NREG-1:0]            busy_q, busy_n, upd_busy_c;
    logic [NREG-1:0][ROB_W-1:0] tag_q, tag_n, upd_tag_c;

    // Clear every entry whose producer commits this cycle (tag must still match).
    function automatic logic [NREG-1:0] commit_clear(input logic [NREG-1:0]            b,
                                                     input logic [NREG-1:0][ROB_W-1:0] t);
        logic [NREG-1:0] r;
        logic [RA_W-1:0] rd;
        r = b;
        for (int unsigned p = 0; p < COMMIT_W; p++) begin
            rd = cmt_rd[p*RA_W +: RA_W];
            if (cmt_valid[p] && cmt_regwrite[p] && b[rd] &&
                (t[rd] == cmt_rob[p*ROB_W +: ROB_W]))
                r[rd] = 1'b0;
        end
        return r;
    endfunction

    // Operand lookup: registered table, overridden by the youngest older writer in the group.
    always_comb begin
        logic [RA_W-1:0] rs1, rs2, rdj;
        q_j      = '0;
        q_k      = '0;
        q_j_busy = '0;
        q_k_busy = '0;
        rs1      = '0;
        rs2      = '0;
        rdj      = '0;
        for (int unsigned i = 0; i < ISSUE_W; i++) begin
            rs1 = iss_rs1[i*RA_W +: RA_W];
            rs2 = iss_rs2[i*RA_W +: RA_W];
            q_j_busy[i]           = busy_q[rs1];
            q_j[i*ROB_W +: ROB_W] = tag_q[rs1];
            q_k_busy[i]           = busy_q[rs2];
            q_k[i*ROB_W +: ROB_W] = tag_q[rs2];
            for (int unsigned j = 0; j < ISSUE_W; j++) begin
                rdj = iss_rd[j*RA_W +: RA_W];
                if ((j < i) && iss_valid[j] && iss_writes[j] && (rdj != '0)) begin
                    if (rdj == rs1) begin
                        q_j_busy[i]           = 1'b1;
                        q_j[i*ROB_W +: ROB_W] = iss_rob[j*ROB_W +: ROB_W];
                    end
                    if (rdj == rs2) begin
                        q_k_busy[i]           = 1'b1;
                        q_k[i*ROB_W +: ROB_W] = iss_rob[j*ROB_W +: ROB_W];
                    end
                end
            end
            if (rs1 == '0) begin
                q_j_busy[i]           = 1'b0;
                q_j[i*ROB_W +: ROB_W] = '0;
            end
            if (rs2 == '0) begin
                q_k_busy[i]           = 1'b0;
                q_k[i*ROB_W +: ROB_W] = '0;
            end
        end
        if (!reset) begin
            q_j      = '0;
            q_k      = '0;
            q_j_busy = '0;
            q_k_busy = '0;
        end
    end

    // Table after this cycle's commits, then issues (issue wins, higher slot wins).
    always_comb begin
        logic [RA_W-1:0] rd;
        rd         = '0;
        upd_busy_c = commit_clear(busy_q, tag_q);
        upd_tag_c  = tag_q;
        for (int unsigned i = 0; i < ISSUE_W; i++) begin
            rd = iss_rd[i*RA_W +: RA_W];
            if (iss_valid[i] && iss_writes[i] && (rd != '0)) begin
                upd_busy_c[rd] = 1'b1;
                upd_tag_c[rd]  = iss_rob[i*ROB_W +: ROB_W];
            end
        end
    end

`ifdef REGSTAT_CKPT_EN
    logic [NREG-1:0]            ck_busy_q [NCKPT];
    logic [NREG-1:0]            ck_busy_n [NCKPT];
    logic [NREG-1:0][ROB_W-1:0] ck_tag_q  [NCKPT];
    logic [NREG-1:0][ROB_W-1:0] ck_tag_n  [NCKPT];
    logic [CK_W-1:0]            head_q, head_n, tail_q, tail_n;
    logic [CK_W:0]              cnt_q, cnt_n;
    logic                       full_c, take_c;

    assign full_c    = (cnt_q == (CK_W+1)'(NCKPT));
    assign take_c    = ckpt_take && !full_c && !ckpt_restore && !flush;
    assign ckpt_id   = head_q;
    assign ckpt_full = full_c;

    // Ring bookkeeping: free retires first, then flush / restore / take.
    always_comb begin
        busy_n = upd_busy_c;
        tag_n  = upd_tag_c;
        head_n = head_q;
        tail_n = tail_q;
        cnt_n  = cnt_q;
        for (int unsigned k = 0; k < NCKPT; k++) begin
            ck_busy_n[k] = commit_clear(ck_busy_q[k], ck_tag_q[k]);
            ck_tag_n[k]  = ck_tag_q[k];
        end
        if (ckpt_free && (cnt_q != '0)) begin
            tail_n = tail_q + CK_W'(1);
            cnt_n  = cnt_q - (CK_W+1)'(1);
        end
        if (flush) begin
            busy_n = '0;
            tag_n  = '0;
            head_n = '0;
            tail_n = '0;
            cnt_n  = '0;
            for (int unsigned k = 0; k < NCKPT; k++) begin
                ck_busy_n[k] = '0;
                ck_tag_n[k]  = '0;
            end
        end else if (ckpt_restore) begin
            busy_n = commit_clear(ck_busy_q[ckpt_restore_id], ck_tag_q[ckpt_restore_id]);
            tag_n  = ck_tag_q[ckpt_restore_id];
            head_n = ckpt_restore_id;
            cnt_n  = (CK_W+1)'(CK_W'(ckpt_restore_id - tail_n));
        end else if (take_c) begin
            ck_busy_n[head_q] = upd_busy_c;
            ck_tag_n[head_q]  = upd_tag_c;
            head_n            = head_q + CK_W'(1);
            cnt_n             = cnt_n + (CK_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            for (int unsigned k = 0; k < NCKPT; k++) begin
                ck_busy_q[k] <= '0;
                ck_tag_q[k]  <= '0;
            end
        end else begin
            head_q <= head_n;
            tail_q <= tail_n;
            cnt_q  <= cnt_n;
            for (int unsigned k = 0; k < NCKPT; k++) begin
                ck_busy_q[k] <= ck_busy_n[k];
                ck_tag_q[k]  <= ck_tag_n[k];
            end
        end
    end
`else
    logic unused_ckpt;

    always_comb begin
        busy_n = upd_busy_c;
        tag_n  = upd_tag_c;
        if (flush || ckpt_restore) begin
            busy_n = '0;
            tag_n  = '0;
        end
    end

    assign ckpt_id     = '0;
    assign ckpt_full   = reset;
    assign unused_ckpt = ^{ckpt_take, ckpt_free, ckpt_restore_id};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
            tag_q  <= '0;
        end else begin
            busy_q <= busy_n;
            tag_q  <= tag_n;
        end
    end

endmodule

// File: doc/regstat_ckpt.md
REGSTAT_CKPT -- requirements
Module: regstat_ckpt

Interface
REQ-001 SHALL have parameter NREG, default 32, meaning number of architectural registers; RA_W = clog2(NREG).
REQ-002 SHALL have parameter ROB_W, default 4, meaning ROB tag width.
REQ-003 SHALL have parameter ISSUE_W, default 2, meaning issue slots per cycle; slot 0 is oldest.
REQ-004 SHALL have parameter COMMIT_W, default 2, meaning commit ports per cycle.
REQ-005 SHALL have parameter NCKPT, default 4, meaning checkpoint slots, which must be a power of two.
REQ-006 SHALL have ports `clk` (in, 1, clock) and `reset` (in, 1, asynchronous, active-low).
REQ-007 SHALL have issue ports: `iss_valid` (in, ISSUE_W); `iss_writes` (in, ISSUE_W); `iss_rd`, `iss_rs1`, `iss_rs2` (in, ISSUE_W*RA_W); `iss_rob` (in, ISSUE_W*ROB_W).
REQ-008 SHALL have operand outputs: `q_j`, `q_k` (out, ISSUE_W*ROB_W, producer tags) and `q_j_busy`, `q_k_busy` (out, ISSUE_W, operand not yet in register file).
REQ-009 SHALL have commit ports `cmt_valid`, `cmt_regwrite` (in, COMMIT_W), `cmt_rd` (in, COMMIT_W*RA_W) and `cmt_rob` (in, COMMIT_W*ROB_W).
REQ-010 SHALL have `flush` (in, 1): mispredict or exception, which discards all speculative state.
REQ-011 SHALL have checkpoint ports `ckpt_take`, `ckpt_restore`, `ckpt_free` (in, 1); `ckpt_restore_id` (in, clog2(NCKPT)); `ckpt_id` (out, clog2(NCKPT), id that the next take allocates); `ckpt_full` (out, 1).

Function
REQ-012 SHALL hold one entry {busy, tag} per register; register 0 SHALL never become busy, and reads of it SHALL return busy=0, tag=0.
REQ-013 SHALL drive operand reads combinationally from the registered table, with an intra-group bypass:
- applies when an older slot j<i has iss_valid&iss_writes, its rd equals the source, and rd≠0;
- the output is then busy=1 and tag=iss_rob[j];
- the youngest such j wins.
REQ-014 SHALL NOT reflect same-cycle commits in reads; the consumer receives the tag and the ROB/CDB forwards the value.
REQ-015 SHALL clear an entry at the clock edge when commit port p has cmt_valid&cmt_regwrite, the entry is busy, and entry.tag==cmt_rob[p].
- A tag mismatch leaves the entry unchanged.
REQ-016 SHALL set an entry to {1, iss_rob[i]} at the clock edge when slot i has iss_valid&iss_writes and rd≠0.
- If several slots target the same rd, the highest slot wins.
- If an issue and a commit hit the same rd, the issue wins.
REQ-017 SHALL, on `flush`, clear every entry and every checkpoint at the next edge and reset the ring to empty; flush overrides issue, commit, take and restore.

Checkpoints (REGSTAT_CKPT_EN)
REQ-018 SHALL manage checkpoints as a FIFO ring with head, tail and count.
- `ckpt_id` = head.
- `ckpt_full` = (count==NCKPT).
REQ-019 SHALL, on `ckpt_take` with !ckpt_full, store into slot head the table value including all of this cycle's issue and commit updates, then advance head and increment count.
- A take while full SHALL be ignored.
- The issuer guarantees the branch is the youngest valid slot of its group.
REQ-020 SHALL apply every commit clear (REQ-015) to all live checkpoints as well as to the table.
REQ-021 SHALL, on `ckpt_restore`:
- load the table from slot ckpt_restore_id, with same-cycle commit clears applied;
- set head=ckpt_restore_id, which frees that slot and all younger slots;
- recompute count;
- ignore issue and take in that cycle.
REQ-022 SHALL, on `ckpt_free` with count>0, advance tail and decrement count; the branch committed correctly.
REQ-023 SHALL, on simultaneous `ckpt_free` and `ckpt_take`, perform both, leaving count unchanged.
REQ-024 SHALL, on simultaneous `ckpt_restore` and `ckpt_free`, apply the free first.

Reset
REQ-025 SHALL, while reset=0, asynchronously clear all entries and checkpoints and set head=tail=count=0.
- Outputs during reset: q_j, q_k, busy flags, ckpt_id = 0; ckpt_full = 0.
- Reset asserted mid-operation SHALL discard all pending state.

Configuration
REQ-026 SHALL use macro `REGSTAT_CKPT_EN`. When defined, REQ-018..REQ-024 apply. When undefined:
- no checkpoint storage is built;
- ckpt_full SHALL be tied 1 and ckpt_id tied 0;
- ckpt_take and ckpt_free SHALL be ignored;
- ckpt_restore SHALL behave exactly as flush.

Verification
REQ-027 Issue slot0 rd=5 rob=3 and slot1 rs1=5 in the same cycle -> slot1 q_j=3, q_j_busy=1; next cycle, a read of r5 returns tag 3, busy 1.
REQ-028 r7 tagged 2, then issue r7 rob=6, then commit rd=7 rob=2 -> r7 remains {1,6}; then commit rob=6 -> r7 becomes {0,x} with busy 0.
REQ-029 Issue and commit r9 (tag match) in the same cycle -> r9={1,new tag}; issue rd=0 -> reads of r0 remain busy 0.
REQ-030 r4 tagged 1, take ckpt (id 0), issue r4 rob=8, commit rob=1, restore id 0 -> r4 not busy, count=0, ckpt_id=0.
REQ-031 Take NCKPT checkpoints -> ckpt_full=1 and a further take is ignored; take+free in one cycle -> count unchanged and ckpt_id advances.
REQ-032 Flush with issue pending, then deassert reset mid-stream -> all busy flags 0 and ckpt_full=0; without REGSTAT_CKPT_EN, ckpt_restore clears the table.
